// File: rtl/modn_digit_chain.sv
// Cascaded modulo-MOD counting chain of DIGITS registered digits.
// Flags whole-chain wrap with one-cycle carry/borrow pulses and a sticky overflow flag.
module modn_digit_chain #(
    parameter int DIGITS = 2,
    parameter int MOD    = 5,
    parameter int DW     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    input  logic                 clr_ovf,
    output logic [DIGITS*DW-1:0] digits,
    output logic                 carry_out,
    output logic                 borrow_out,
    output logic                 ovf_sticky,
    output logic                 at_zero
);

    // One extra bit so MOD == 2^DW is representable and compares never wrap.
    localparam logic [DW:0]   MOD_W  = (DW+1)'(MOD);
    localparam logic [DW:0]   ONE_W  = (DW+1)'(1);
    localparam logic [DW-1:0] DIG_MX = DW'(MOD - 1);

    logic [DIGITS*DW-1:0] digits_q, digits_d;
    logic                 carry_q, carry_d;
    logic                 borrow_q, borrow_d;
    logic                 ovf_q, ovf_d;

    logic                 ripple;
    logic                 bad_load;
    logic [DW-1:0]        dig;

    always_comb begin
        digits_d = digits_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        ripple   = 1'b0;
        bad_load = 1'b0;
        dig      = '0;

        if (load) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                dig = load_val[i*DW +: DW];
                if ({1'b0, dig} >= MOD_W) begin
                    dig      = '0;
                    bad_load = 1'b1;
                end
                digits_d[i*DW +: DW] = dig;
            end
        end else if (inc ^ dec) begin
            // ripple carries/borrows upward; surviving past the top digit means the whole chain wrapped
            ripple = 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                dig = digits_q[i*DW +: DW];
                if (ripple) begin
                    if (inc) begin
                        if (({1'b0, dig} + ONE_W) == MOD_W) begin
                            dig = '0;
                        end else begin
                            dig    = dig + DW'(1);
                            ripple = 1'b0;
                        end
                    end else begin
                        if (dig == '0) begin
                            dig = DIG_MX;
                        end else begin
                            dig    = dig - DW'(1);
                            ripple = 1'b0;
                        end
                    end
                end
                digits_d[i*DW +: DW] = dig;
            end
            carry_d  = ripple & inc;
            borrow_d = ripple & dec;
        end

        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (carry_d || borrow_d || bad_load) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign digits     = digits_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign ovf_sticky = ovf_q;
    assign at_zero    = (digits_q == '0);

endmodule

// File: tb/tb_modn_digit_chain.sv
// Self-checking bench for modn_digit_chain: directed vector table, wrap sequence,
// and random stimulus against an integer-valued reference model.
module tb_modn_digit_chain;

    localparam int DIGITS = 2;
    localparam int MOD    = 5;
    localparam int DW     = 3;
    localparam int W      = DIGITS * DW;
    localparam int TOTAL  = MOD ** DIGITS;

    logic         clk = 1'b0;
    logic         reset, inc, dec, load, clr_ovf;
    logic [W-1:0] load_val;
    logic [W-1:0] digits;
    logic         carry_out, borrow_out, ovf_sticky, at_zero;

    int checks = 0;
    int errors = 0;

    modn_digit_chain #(.DIGITS(DIGITS), .MOD(MOD), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .inc        (inc),
        .dec        (dec),
        .load       (load),
        .load_val   (load_val),
        .clr_ovf    (clr_ovf),
        .digits     (digits),
        .carry_out  (carry_out),
        .borrow_out (borrow_out),
        .ovf_sticky (ovf_sticky),
        .at_zero    (at_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst, inc, dec, ld, clr;
        logic [W-1:0] lv;
        logic [W-1:0] exp_d;
        logic         exp_c, exp_b, exp_o, exp_z;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic i, input logic d, input logic l,
                                input logic c, input int lv1, input int lv0,
                                input int e1, input int e0, input logic ec, input logic eb,
                                input logic eo, input logic ez);
        vec_t v;
        v.rst = r; v.inc = i; v.dec = d; v.ld = l; v.clr = c;
        v.lv    = {DW'(lv1), DW'(lv0)};
        v.exp_d = {DW'(e1), DW'(e0)};
        v.exp_c = ec; v.exp_b = eb; v.exp_o = eo; v.exp_z = ez;
        return v;
    endfunction

    task automatic drive(input logic r, input logic i, input logic d, input logic l,
                         input logic c, input logic [W-1:0] lv);
        reset = r; inc = i; dec = d; load = l; clr_ovf = c; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the chain holds a single integer in 0..MOD^DIGITS-1.
    int m_val;
    bit m_c, m_b, m_o;

    function automatic logic [W-1:0] m_digits();
        logic [W-1:0] r;
        int v;
        r = '0;
        v = m_val;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*DW +: DW] = DW'(v % MOD);
            v = v / MOD;
        end
        return r;
    endfunction

    task automatic m_step(input logic r, input logic i, input logic d, input logic l,
                          input logic c, input logic [W-1:0] lv);
        int pw, dg;
        bit bad;
        bad = 0;
        if (r) begin
            m_val = 0; m_c = 0; m_b = 0; m_o = 0;
        end else begin
            m_c = 0; m_b = 0;
            if (l) begin
                m_val = 0;
                pw = 1;
                for (int k = 0; k < DIGITS; k++) begin
                    dg = int'(lv[k*DW +: DW]);
                    if (dg >= MOD) bad = 1;
                    else m_val += dg * pw;
                    pw *= MOD;
                end
            end else if (i && !d) begin
                if (m_val == TOTAL - 1) begin m_val = 0; m_c = 1; end
                else m_val++;
            end else if (d && !i) begin
                if (m_val == 0) begin m_val = TOTAL - 1; m_b = 1; end
                else m_val--;
            end
            if (c) m_o = 0;
            if (m_c || m_b || bad) m_o = 1;
        end
    endtask

    int pulses;
    logic r_r, r_i, r_d, r_l, r_c;
    logic [W-1:0] r_lv;

    initial begin
        reset = 1'b1; inc = 0; dec = 0; load = 0; clr_ovf = 0; load_val = '0;

        //            rst i d ld clr lv1 lv0  e1 e0  c b o z
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4, 4, 4, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2, 2, 2, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 6, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3, 1, 3, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4, 4, 4, 4, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 7, 5, 0, 0, 0, 0, 1, 1));

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].inc, vecs[k].dec, vecs[k].ld, vecs[k].clr, vecs[k].lv);
            chk($sformatf("vec%0d digits", k), int'(digits), int'(vecs[k].exp_d));
            chk($sformatf("vec%0d carry", k), int'(carry_out), int'(vecs[k].exp_c));
            chk($sformatf("vec%0d borrow", k), int'(borrow_out), int'(vecs[k].exp_b));
            chk($sformatf("vec%0d ovf", k), int'(ovf_sticky), int'(vecs[k].exp_o));
            chk($sformatf("vec%0d at_zero", k), int'(at_zero), int'(vecs[k].exp_z));
        end

        // 25 continuous increments from zero: exactly one carry pulse, on the cycle showing 00.
        drive(1, 0, 0, 0, 0, '0);
        pulses = 0;
        for (int k = 1; k <= TOTAL; k++) begin
            drive(0, 1, 0, 0, 0, '0);
            if (carry_out) begin
                pulses++;
                chk("run25 digits at carry", int'(digits), 0);
                chk("run25 carry cycle", k, TOTAL);
            end
        end
        chk("run25 pulse count", pulses, 1);
        drive(0, 0, 0, 0, 0, '0);
        chk("run25 carry drops", int'(carry_out), 0);

        // Random stimulus against the integer model.
        drive(1, 0, 0, 0, 0, '0);
        m_step(1, 0, 0, 0, 0, '0);
        for (int k = 0; k < 600; k++) begin
            r_r  = ($urandom_range(0, 99) < 2);
            r_l  = ($urandom_range(0, 99) < 6);
            r_i  = ($urandom_range(0, 99) < 65);
            r_d  = ($urandom_range(0, 99) < 35);
            r_c  = ($urandom_range(0, 99) < 10);
            r_lv = W'($urandom);
            drive(r_r, r_i, r_d, r_l, r_c, r_lv);
            m_step(r_r, r_i, r_d, r_l, r_c, r_lv);
            chk("rand digits", int'(digits), int'(m_digits()));
            chk("rand carry", int'(carry_out), int'(m_c));
            chk("rand borrow", int'(borrow_out), int'(m_b));
            chk("rand ovf", int'(ovf_sticky), int'(m_o));
            chk("rand at_zero", int'(at_zero), int'(m_val == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
